// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU operation sequencer:
// ALU select codes, ALUOp encodings, sequencer states and branch kinds.
package alu_seq_pkg;

    localparam logic [3:0] ALU_SEL_AND = 4'd0;
    localparam logic [3:0] ALU_SEL_OR  = 4'd1;
    localparam logic [3:0] ALU_SEL_ADD = 4'd2;
    localparam logic [3:0] ALU_SEL_SUB = 4'd6;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        RESP
    } seqStateT;

    typedef enum logic [1:0] {
        NONE,
        BEQ,
        BNE
    } brKindT;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of ALUOp/funct3/funct7[5] into the ALU select,
// an illegal-encoding flag and the branch kind.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] sel,
    output logic       illegal,
    output brKindT     brKind
);

    // Map the instruction fields onto an ALU operation and branch kind
    always_comb begin
        sel     = ALU_SEL_ADD;
        illegal = 1'b0;
        brKind  = NONE;
        case (aluOp)
            ALUOP_MEM: sel = ALU_SEL_ADD;
            ALUOP_BR: begin
                case (funct3)
                    3'b000: begin
                        sel    = ALU_SEL_SUB;
                        brKind = BEQ;
                    end
                    3'b001: begin
                        sel    = ALU_SEL_SUB;
                        brKind = BNE;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            ALUOP_R: begin
                case (funct3)
                    3'b000:  sel = funct7b5 ? ALU_SEL_SUB : ALU_SEL_ADD;
                    3'b111:  sel = ALU_SEL_AND;
                    3'b110:  sel = ALU_SEL_OR;
                    default: illegal = 1'b1;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000:  sel = ALU_SEL_ADD;
                    3'b111:  sel = ALU_SEL_AND;
                    3'b110:  sel = ALU_SEL_OR;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU interface: accepts one decoded operation per
// valid/ready handshake, drives operands/select to the combinational ALU,
// captures result and zero flag, and returns a response.
// Optional: ALU_SEQ_BACK_TO_BACK_EN lets a new request be accepted in the
// same cycle the response completes.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_alu_op,
    input  logic [2:0]   req_funct3,
    input  logic         req_funct7_5,
    input  logic [N-1:0] req_rs1,
    input  logic [N-1:0] req_rs2,
    input  logic [N-1:0] req_imm,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_out,
    input  logic         alu_zflag,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_branch_taken,
    output logic         rsp_illegal
);

    seqStateT     state;
    brKindT       brKindQ;
    logic [3:0]   decSel;
    logic         decIllegal;
    brKindT       decBrKind;
    logic         accept;
    logic [N-1:0] operandB;

    alu_op_decode uDecode (
        .aluOp    (req_alu_op),
        .funct3   (req_funct3),
        .funct7b5 (req_funct7_5),
        .sel      (decSel),
        .illegal  (decIllegal),
        .brKind   (decBrKind)
    );

`ifdef ALU_SEQ_BACK_TO_BACK_EN
    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
    assign req_ready = (state == IDLE);
`endif

    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign operandB  = ((req_alu_op == ALUOP_MEM) || (req_alu_op == ALUOP_I)) ? req_imm : req_rs2;

    // Sequencer FSM: accept -> drive ALU -> sample result -> hold response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            brKindQ          <= NONE;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_sel          <= '0;
            rsp_result       <= '0;
            rsp_branch_taken <= 1'b0;
            rsp_illegal      <= 1'b0;
        end else if (accept) begin
            // Acceptance is handled ahead of the state case so the RESP-state
            // back-to-back path shares the exact same capture logic as IDLE.
            if (decIllegal) begin
                rsp_illegal      <= 1'b1;
                rsp_result       <= '0;
                rsp_branch_taken <= 1'b0;
                state            <= RESP;
            end else begin
                alu_a       <= req_rs1;
                alu_b       <= operandB;
                alu_sel     <= decSel;
                brKindQ     <= decBrKind;
                rsp_illegal <= 1'b0;
                state       <= DRIVE;
            end
        end else begin
            case (state)
                IDLE:  state <= IDLE;
                DRIVE: state <= SAMPLE;
                SAMPLE: begin
                    rsp_result <= alu_out;
                    case (brKindQ)
                        BEQ:     rsp_branch_taken <= alu_zflag;
                        BNE:     rsp_branch_taken <= ~alu_zflag;
                        default: rsp_branch_taken <= 1'b0;
                    endcase
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
